instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetcher feeding a small circular
// prefetch FIFO, with redirect flush and discard of in-flight stale responses.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;

    typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

    state_t                 state;
    logic [31:0]            fetch_pc;
    logic [DEPTH-1:0][31:0] buf_instr;
    logic [DEPTH-1:0][31:0] buf_pc;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [2:0]             count;
    logic                   push;
    logic                   pop;
    logic                   unused_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign unused_bits = ^redirect_pc[1:0];
    assign if_valid    = (count != 3'd0);
    assign if_instr    = buf_instr[head];
    assign if_pc       = buf_pc[head];
    assign pop         = if_valid && if_ready;
    // A response is kept only if no redirect has touched it, including this cycle.
    assign push        = (state == WAIT) && mem_ack && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            mem_req   <= 1'b0;
            mem_addr  <= RESET_PC;
            buf_instr <= '0;
            buf_pc    <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // Nothing is outstanding here, so count alone bounds occupancy.
                    if (!redirect_valid && count < 3'(DEPTH)) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= FETCH;
                        if (!redirect_valid) fetch_pc <= fetch_pc + 32'd4;
                    end else if (redirect_valid) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase

            if (redirect_valid) fetch_pc <= {redirect_pc[31:2], 2'b00};

            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    buf_instr[tail] <= mem_rdata;
                    buf_pc[tail]    <= mem_addr;
                    tail            <= ptr_inc(tail);
                end
                if (pop) head <= ptr_inc(head);
                case ({push, pop})
                    2'b10:   count <= count + 3'd1;
                    2'b01:   count <= count - 3'd1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule
